gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for a 2-input, 1-bit combinational gate such as nor_gate. On a start pulse it drives all four input vectors onto the gate, waits a programmable settle time per vector, and samples the gate output. It compares each sample against a parameterised expected truth table and reports pass/fail, a per-vector fail mask and the observed truth table. It sits between the gate under test and a system-level test/status controller.

Parameters:
EXP_TT, 4'b0001, expected output per vector index {a,b} (bit i = expected y for vector i); default is NOR.
SETTLE, 2, cycles each vector is held before sampling; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a test run; sampled only in IDLE
abort  input  1  synchronous abort of a run in progress
gate_y  input  1  output of the gate under test
gate_a  output  1  drive to gate input a
gate_b  output  1  drive to gate input b
busy  output  1  high while a run is in progress (DRIVE/CHECK)
done  output  1  one-cycle pulse at run completion
pass  output  1  1 when the last completed run had fail_mask == 0
fail_mask  output  4  bit i set if vector i mismatched EXP_TT[i]
observed_tt  output  4  bit i = sampled gate_y for vector i

Behaviour:
- Reset values: gate_a=0, gate_b=0, busy=0, done=0, pass=0, fail_mask=0, observed_tt=0; state=IDLE, vector index idx=0, settle counter=0.
- Vector order: idx 0..3 drives {gate_a,gate_b} = 00, 01, 10, 11 (idx = {a,b}).
- States: IDLE, DRIVE, CHECK, DONE. All outputs are registered.
- IDLE: gate_a/gate_b=0, busy=0. If start=1, go to DRIVE at the next edge. On that same edge: idx=0, vector 00 driven, settle counter=0, fail_mask/observed_tt/pass cleared.
- DRIVE: busy=1. Settle counter increments each cycle. When counter == SETTLE-1, go to CHECK. The vector is held stable for exactly SETTLE cycles.
- CHECK (1 cycle): busy=1.
  - Sample gate_y into observed_tt[idx].
  - Set fail_mask[idx] = gate_y ^ EXP_TT[idx].
  - If idx==3, go to DONE. Otherwise idx+1, drive the next vector, reset the counter and go to DRIVE on the same edge.
- Per-vector cost is SETTLE+1 cycles. busy stays high for exactly 4*(SETTLE+1) cycles.
- DONE (1 cycle): done=1, busy=0, pass = (final fail_mask == 0), gate_a/gate_b return to 0. Next state is IDLE.
- Results: pass, fail_mask and observed_tt hold until the next accepted start, abort, or reset.
- start while busy or in DONE is ignored, with no queuing. start held high continuously gives back-to-back runs separated by one IDLE cycle.
- abort in DRIVE or CHECK: next edge goes to IDLE with busy=0, gate_a/gate_b=0, no done pulse, pass=0, fail_mask=0, observed_tt=0.
  - abort has priority over the CHECK update in the same cycle.
  - abort in IDLE or DONE has no effect; the DONE-cycle pulse and its results still complete.
- rst mid-run: all registers return to reset values at the next edge, with no done pulse.
- The gate output is assumed combinational; sampling at the end of the settle window is the only timing dependence.

Test Plan:
1. Reset: assert rst 2 cycles with start=1 -> all outputs 0, state IDLE, no busy.
2. Good NOR (y=~(a|b)), SETTLE=2, one-cycle start -> busy high 12 cycles; gate_{a,b} sequence 00,01,10,11 each held 3 cycles; done pulses next cycle; pass=1, fail_mask=0000, observed_tt=0001.
3. Stuck-at-0 gate (gate_y=0) -> done after 12 busy cycles, pass=0, fail_mask=0001, observed_tt=0000.
4. Wrong gate (AND, y=a&b), SETTLE=1 -> busy 8 cycles, observed_tt=1000, fail_mask=1001, pass=0.
5. start re-pulsed during vector 1 -> ignored, results identical to test 2. Then abort during vector 2 DRIVE -> next cycle busy=0, gate_a/gate_b=0, no done, fail_mask=0000, pass=0. A following start gives clean results matching test 2.
6. rst asserted in CHECK of vector 3 -> no done pulse, all outputs 0. start held high across two runs -> two done pulses spaced 4*(SETTLE+1)+2 cycles apart.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for a 2-input, 1-bit gate: walks vectors 00..11,
// samples the gate after a settle window and reports the results.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       begin a run (sampled only in IDLE)
//   abort       cancel a run in progress (DRIVE/CHECK)
//   gate_y      output of the gate under test
//   gate_a/b    drives to the gate inputs, vector idx = {a,b}
//   busy        high while a run is in progress
//   done        one-cycle completion pulse
//   pass        last completed run had no mismatches
//   fail_mask   bit i set if vector i mismatched EXP_TT[i]
//   observed_tt bit i = sampled gate_y for vector i
module gate_bist_ctrl #(
   parameter logic [3:0]  EXP_TT = 4'b0001,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [3:0] observed_tt
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK,
      DONE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

   state_t     state;
   logic [1:0] idx;
   logic [7:0] cnt;
   logic [3:0] chk_mask;
   logic [3:0] chk_tt;

   // Results including the vector being sampled this cycle, so the
   // final pass flag sees the last vector's outcome.
   always_comb begin
      chk_mask      = fail_mask;
      chk_tt        = observed_tt;
      chk_mask[idx] = gate_y ^ EXP_TT[idx];
      chk_tt[idx]   = gate_y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 2'd0;
         cnt         <= 8'd0;
         gate_a      <= 1'b0;
         gate_b      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_mask   <= 4'd0;
         observed_tt <= 4'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= DRIVE;
                  idx         <= 2'd0;
                  cnt         <= 8'd0;
                  gate_a      <= 1'b0;
                  gate_b      <= 1'b0;
                  busy        <= 1'b1;
                  pass        <= 1'b0;
                  fail_mask   <= 4'd0;
                  observed_tt <= 4'd0;
               end
            end
            DRIVE, CHECK: begin
               if (abort) begin
                  // Abort wins over any CHECK update this cycle.
                  state       <= IDLE;
                  busy        <= 1'b0;
                  gate_a      <= 1'b0;
                  gate_b      <= 1'b0;
                  pass        <= 1'b0;
                  fail_mask   <= 4'd0;
                  observed_tt <= 4'd0;
               end else if (state == DRIVE) begin
                  if (cnt == CNT_LAST) begin
                     state <= CHECK;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end else begin
                  fail_mask   <= chk_mask;
                  observed_tt <= chk_tt;
                  if (idx == 2'd3) begin
                     state  <= DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     pass   <= (chk_mask == 4'd0);
                     gate_a <= 1'b0;
                     gate_b <= 1'b0;
                  end else begin
                     state            <= DRIVE;
                     idx              <= idx + 2'd1;
                     {gate_a, gate_b} <= idx + 2'd1;
                     cnt              <= 8'd0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (SETTLE=2 and SETTLE=1)
// each driving a table-defined gate model.
module tb_gate_bist_ctrl;

   localparam logic [3:0] EXP = 4'b0001;

   logic       clk;
   logic       rst;
   logic       start [2];
   logic       abort [2];
   logic       gy    [2];
   logic       ga    [2];
   logic       gb    [2];
   logic       busy  [2];
   logic       done  [2];
   logic       pass  [2];
   logic [3:0] fm    [2];
   logic [3:0] ot    [2];
   logic [3:0] tt    [2];

   int checks;
   int failures;

   assign gy[0] = tt[0][{ga[0], gb[0]}];
   assign gy[1] = tt[1][{ga[1], gb[1]}];

   gate_bist_ctrl #(.EXP_TT(EXP), .SETTLE(2)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
      .gate_y(gy[0]), .gate_a(ga[0]), .gate_b(gb[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .fail_mask(fm[0]), .observed_tt(ot[0])
   );

   gate_bist_ctrl #(.EXP_TT(EXP), .SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
      .gate_y(gy[1]), .gate_a(ga[1]), .gate_b(gb[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .fail_mask(fm[1]), .observed_tt(ot[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int settle_of(input int s);
      return (s == 0) ? 2 : 1;
   endfunction

   // Pulses start and observes one run until its done pulse.
   task automatic run_capture(
      input  int         s,
      input  int         repulse,
      output int         bcnt,
      output int         serr,
      output int         gap,
      output logic       p,
      output logic [3:0] f,
      output logic [3:0] o
   );
      int st;
      int last_busy;
      st = settle_of(s);
      last_busy = 0;
      bcnt = 0;
      serr = 0;
      gap = -1;
      p = 1'b0;
      f = 4'd0;
      o = 4'd0;
      start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (busy[s]) begin
            if ({ga[s], gb[s]} != 2'(bcnt / (st + 1)))
               serr++;
            bcnt++;
            last_busy = c;
         end
         if (done[s]) begin
            gap = c - last_busy;
            p = pass[s];
            f = fm[s];
            o = ot[s];
            break;
         end
         start[s] = (c == repulse);
         @(negedge clk);
      end
      start[s] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start[0] = 1'b1;
      start[1] = 1'b1;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({ga[s], gb[s], busy[s], done[s], pass[s],
              fm[s], ot[s]} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outs dut%0d got=%b %b %b %b %b %b %b",
                     s, ga[s], gb[s], busy[s], done[s], pass[s],
                     fm[s], ot[s]);
         end
      end
      start[0] = 1'b0;
      start[1] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle busy=%b%b want=00",
                  busy[0], busy[1]);
      end
   endtask

   // Runs one instance on a gate with truth table g and compares
   // against the table-level model.
   task automatic test_run(input int s, input logic [3:0] g,
                           input int repulse, input string nm);
      int bcnt, serr, gap;
      logic p;
      logic [3:0] f, o;
      logic [3:0] ef;
      int eb;
      tt[s] = g;
      ef = g ^ EXP;
      eb = 4 * (settle_of(s) + 1);
      run_capture(s, repulse, bcnt, serr, gap, p, f, o);
      checks++;
      if (bcnt !== eb) begin
         failures++;
         $display("FAIL %s_busy got=%0d want=%0d", nm, bcnt, eb);
      end
      checks++;
      if (serr !== 0) begin
         failures++;
         $display("FAIL %s_seq got=%0d bad cycles want=0", nm, serr);
      end
      checks++;
      if (gap !== 1) begin
         failures++;
         $display("FAIL %s_done_gap got=%0d want=1", nm, gap);
      end
      checks++;
      if (o !== g || f !== ef || p !== (ef == 4'd0)) begin
         failures++;
         $display("FAIL %s_result got=%b/%b/%b want=%b/%b/%b",
                  nm, o, f, p, g, ef, (ef == 4'd0));
      end
      @(negedge clk);
      checks++;
      if (done[s] !== 1'b0 || ot[s] !== g || fm[s] !== ef) begin
         failures++;
         $display("FAIL %s_hold done=%b tt=%b mask=%b want 0/%b/%b",
                  nm, done[s], ot[s], fm[s], g, ef);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         int s;
         logic [3:0] g;
         s = int'($urandom_range(0, 1));
         g = 4'($urandom_range(0, 15));
         test_run(s, g, -1, "rand");
      end
   endtask

   task automatic test_abort;
      logic seen;
      test_run(0, 4'b0001, 4, "repulse");
      tt[0] = 4'b0000;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (fm[0] !== 4'b0001 || {ga[0], gb[0]} !== 2'b10) begin
         failures++;
         $display("FAIL pre_abort mask=%b vec=%b%b want=0001 10",
                  fm[0], ga[0], gb[0]);
      end
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checks++;
      if ({busy[0], ga[0], gb[0], done[0], pass[0],
           fm[0], ot[0]} !== 13'd0) begin
         failures++;
         $display("FAIL abort_clear got=%b%b%b%b%b %b %b want=0",
                  busy[0], ga[0], gb[0], done[0], pass[0],
                  fm[0], ot[0]);
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done[0] || busy[0]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL abort_quiet got=activity want=none");
      end
      test_run(0, 4'b0001, -1, "after_abort");
      test_run(0, 4'b0001, -1, "pre_done_abort");
      tt[0] = 4'b0001;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (11) @(negedge clk);
      while (!done[0] && busy[0]) @(negedge clk);
      checks++;
      if (done[0] !== 1'b1) begin
         failures++;
         $display("FAIL done_seen got=%b want=1", done[0]);
      end
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checks++;
      if (pass[0] !== 1'b1 || ot[0] !== 4'b0001) begin
         failures++;
         $display("FAIL abort_in_done pass=%b tt=%b want=1 0001",
                  pass[0], ot[0]);
      end
   endtask

   task automatic test_reset_mid;
      int d1, d2;
      tt[0] = 4'b0001;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy[0], ga[0], gb[0], done[0], pass[0],
           fm[0], ot[0]} !== 13'd0) begin
         failures++;
         $display("FAIL rst_mid got=%b%b%b%b%b %b %b want=0",
                  busy[0], ga[0], gb[0], done[0], pass[0],
                  fm[0], ot[0]);
      end
   endtask

   task automatic test_back_to_back;
      int d1, d2;
      d1 = -1;
      d2 = -1;
      tt[0] = 4'b0001;
      start[0] = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done[0]) begin
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
         if (d2 >= 0) break;
      end
      start[0] = 1'b0;
      checks++;
      if (d1 < 0 || d2 < 0 || d2 - d1 !== 14) begin
         failures++;
         $display("FAIL b2b_spacing got=%0d,%0d want gap 14", d1, d2);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || pass[0] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_drain busy=%b pass=%b want=0 1",
                  busy[0], pass[0]);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b0;
         abort[s] = 1'b0;
      end
      tt[0] = 4'b0001;
      tt[1] = 4'b0001;
      @(negedge clk);
      test_reset();
      test_run(0, 4'b0001, -1, "good_nor");
      test_run(0, 4'b0000, -1, "stuck0");
      test_run(1, 4'b1000, -1, "and_gate");
      test_run(1, 4'b0001, -1, "nor_s1");
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
